phy_mdio: RTL
=============

# phy_mdio

IEEE 802.3 Clause 22 MDIO management master for one GigE PHY on the DE2-115 front-end, instantiated per PHY next to `phy_init`. It accepts single register read/write commands once `phy_ready` (from `phy_init`) is high, serialises the 64-bit management frame on MDC/MDIO, and returns read data with a turnaround-error flag. Top level forms the `phy*_gm_mio` tristate from `mdio_o`/`mdio_oe` and drives `phy*_gm_mdc` from `mdc`.

## Interface
- `CLK_DIV`, 10, `clk_50` cycles per MDC half-period; minimum 2; 10 gives 2.5 MHz MDC.
- `clk_50`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `phy_ready`  in  1  PHY strap/reset sequence complete; gates command acceptance.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  block idle and `phy_ready` high; transfer when `cmd_valid && cmd_ready`.
- `cmd_write`  in  1  1 = write, 0 = read.
- `cmd_phy_addr`  in  5  PHYAD field.
- `cmd_reg_addr`  in  5  REGAD field.
- `cmd_wdata`  in  16  write data; ignored on reads.
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_rdata`  out  16  read data; held until the next response.
- `rsp_err`  out  1  read turnaround bit was not 0; held with `rsp_rdata`.
- `mdc`  out  1  management clock.
- `mdio_o`  out  1  MDIO output value.
- `mdio_oe`  out  1  MDIO output enable.
- `mdio_i`  in  1  MDIO pin value.

## Operation
- States: IDLE, XFER, GAP.
- IDLE: `cmd_ready = phy_ready`. On accept, load 64-bit shift register {32 ones, 2'b01, op, phy_addr, reg_addr, TA, data}; op = 2'b01 write / 2'b10 read; write TA = 2'b10, data = `cmd_wdata`; read TA and data = all ones. Clear slot counter; go to XFER.
- XFER: 64 bit slots, 0..63, each 2*`CLK_DIV` cycles. First half `mdc` = 0, second half `mdc` = 1. `mdio_o` updates to the slot's MSB on the first cycle of the slot (MDC falling edge).
- `mdio_oe`: writes, high for slots 0..63. Reads, high for slots 0..45 and low for slots 46..63. `mdio_o` = 1 whenever `mdio_oe` = 0.
- Read sampling: `mdio_i` is registered on the last `mdc`-low cycle of each slot 47..63. Slot 47 gives the TA bit; slots 48..63 give D15..D0, MSB first.
- After slot 63, go to GAP and pulse `rsp_valid`.
  - Reads: `rsp_rdata` = captured data; `rsp_err` = (TA sample != 0). Data is captured regardless of error.
  - Writes: `rsp_rdata` = 0, `rsp_err` = 0.
- GAP: one idle slot (2*`CLK_DIV` cycles) with `mdc` = 0 and `mdio_oe` = 0, then IDLE.
- `phy_ready` falling mid-frame does not abort the frame. Only acceptance is gated.
- `cmd_valid` while not ready is ignored; the command must be held until accepted.
- Reset, including mid-frame: next cycle state = IDLE, `mdc` = 0, `mdio_oe` = 0, `mdio_o` = 1, `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_err` = 0, counters cleared. No partial response.

## Timing
- Accept at cycle T; slot 0 starts at T+1.
- Slot s spans T+1+2s·`CLK_DIV` .. T+(2s+2)·`CLK_DIV`.
- `rsp_valid` high exactly at cycle T+1+128·`CLK_DIV`.
- `cmd_ready` re-asserts at T+1+130·`CLK_DIV` (if `phy_ready`).
- With `CLK_DIV` = 10: response at T+1281, ready at T+1301.
- Divider counter width clog2(`CLK_DIV`); slot counter 6 bits, no wrap beyond 63.
- `mdc` is registered, glitch-free and 50 % duty. It never toggles in IDLE or GAP.

## Structure
- Shared package `gige_pkg`: `MDIO_OP_READ` = 2'b10, `MDIO_OP_WRITE` = 2'b01, `MDIO_ST` = 2'b01, `MDIO_PRE_LEN` = 32, `MDIO_FRAME_LEN` = 64, `MDIO_RD_OE_LAST` = 45.
- Sub-module `mdc_gen`: `CLK_DIV` divider with enable. Outputs `mdc`, `slot_start` (first cycle of slot) and `sample_strb` (last low cycle).
- Shift register, slot counter and FSM live in `phy_mdio`.

## Test plan
- Write: `CLK_DIV` = 2, phy 5'h01, reg 5'h00, data 16'h1140. Expect:
  - MDIO stream of 32 ones, then 01 01 00001 00000 10 0001000101000000.
  - `mdio_oe` high for all 64 slots.
  - `rsp_valid` at T+257 with `rsp_err` = 0.
- Read: PHY model drives TA 0 then 16'h796D. Expect:
  - `mdio_oe` drops at slot 46.
  - `rsp_rdata` = 16'h796D, `rsp_err` = 0.
  - Single `rsp_valid` pulse.
- Read with no PHY (`mdio_i` pulled to 1) → `rsp_rdata` = 16'hFFFF, `rsp_err` = 1.
- `phy_ready` = 0 with `cmd_valid` held → `cmd_ready` = 0 and no MDC edges. Raise `phy_ready` → accept the next cycle.
- Back-to-back commands, second held valid during the first → second accepted at exactly T+1+130·`CLK_DIV`, with ≥1 idle slot between frames.
- `reset` asserted at slot 20 of a write, then deasserted → next cycle `mdc` = 0, `mdio_oe` = 0, no `rsp_valid`. A new read completes correctly.

Source files
------------

// File: rtl/gige_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | gige_pkg : shared GigE front-end constants and MDIO frame helpers |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package gige_pkg;

  localparam logic [1:0] MDIO_OP_READ    = 2'b10;
  localparam logic [1:0] MDIO_OP_WRITE   = 2'b01;
  localparam logic [1:0] MDIO_ST         = 2'b01;
  localparam int         MDIO_PRE_LEN    = 32;
  localparam int         MDIO_FRAME_LEN  = 64;
  localparam logic [5:0] MDIO_RD_OE_LAST = 6'd45;
  localparam logic [5:0] MDIO_SLOT_TA    = 6'd47;
  localparam logic [5:0] MDIO_SLOT_LAST  = 6'd63;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_GAP  = 2'd2
  } mdio_state_e;

  // Reads leave TA and data as ones so the released line idles high.
  function automatic logic [MDIO_FRAME_LEN-1:0] mdio_frame(
    input logic        wr,
    input logic [4:0]  phy_addr,
    input logic [4:0]  reg_addr,
    input logic [15:0] wdata
  );
    if (wr)
      mdio_frame = {{MDIO_PRE_LEN{1'b1}}, MDIO_ST, MDIO_OP_WRITE,
                    phy_addr, reg_addr, 2'b10, wdata};
    else
      mdio_frame = {{MDIO_PRE_LEN{1'b1}}, MDIO_ST, MDIO_OP_READ,
                    phy_addr, reg_addr, 2'b11, 16'hFFFF};
  endfunction

endpackage
`default_nettype wire

// File: rtl/phy_mdio_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | phy_mdio_if : command/response and MDC/MDIO pin bundle             |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface phy_mdio_if;
  logic        phy_ready;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [4:0]  cmd_phy_addr;
  logic [4:0]  cmd_reg_addr;
  logic [15:0] cmd_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic        mdc;
  logic        mdio_o;
  logic        mdio_oe;
  logic        mdio_i;

  modport master (
    output phy_ready, cmd_valid, cmd_write, cmd_phy_addr, cmd_reg_addr,
           cmd_wdata, mdio_i,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, mdc, mdio_o, mdio_oe
  );

  modport slave (
    input  phy_ready, cmd_valid, cmd_write, cmd_phy_addr, cmd_reg_addr,
           cmd_wdata, mdio_i,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, mdc, mdio_o, mdio_oe
  );
endinterface
`default_nettype wire

// File: rtl/phy_mdio_mdc_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mdc_gen : MDC divider with slot start/sample/end strobes           |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module mdc_gen #(
  parameter int CLK_DIV = 10
) (
  input  wire  clk_50,
  input  wire  reset,
  input  logic i_en,
  input  logic i_gap,
  output logic o_mdc,
  output logic o_slot_start,
  output logic o_sample_strb,
  output logic o_slot_end
);

  localparam int            CW     = $clog2(CLK_DIV);
  localparam logic [CW-1:0] C_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          r_half;
  logic          r_mdc;
  logic          w_cnt_wrap;
  logic          w_half_nxt;

  assign w_cnt_wrap = (r_cnt == C_LAST);
  assign w_half_nxt = w_cnt_wrap ? ~r_half : r_half;

  // MDC is the registered half-phase, held low throughout the idle gap slot.
  always_ff @(posedge clk_50) begin
    if (reset || !i_en) begin
      r_cnt  <= '0;
      r_half <= 1'b0;
      r_mdc  <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_wrap ? '0 : r_cnt + 1'b1;
      r_half <= w_half_nxt;
      r_mdc  <= w_half_nxt & ~i_gap;
    end
  end

  assign o_mdc         = r_mdc;
  assign o_slot_start  = i_en & ~r_half & (r_cnt == '0);
  assign o_sample_strb = i_en & ~r_half & w_cnt_wrap;
  assign o_slot_end    = i_en &  r_half & w_cnt_wrap;

endmodule
`default_nettype wire

// File: rtl/phy_mdio.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | phy_mdio : Clause 22 MDIO master, single read/write per command    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module phy_mdio
  import gige_pkg::*;
#(
  parameter int CLK_DIV = 10
) (
  input  wire       clk_50,
  input  wire       reset,
  phy_mdio_if.slave mif
);

  mdio_state_e                r_state;
  mdio_state_e                w_state_nxt;
  logic [MDIO_FRAME_LEN-1:0]  r_sreg;
  logic [5:0]                 r_slot;
  logic                       r_write;
  logic                       r_ta;
  logic [15:0]                r_rd;
  logic                       r_rsp_valid;
  logic [15:0]                r_rsp_rdata;
  logic                       r_rsp_err;
  logic                       w_cmd_ready;
  logic                       w_mdio_oe;
  logic                       w_mdio_o;
  logic                       w_accept;
  logic                       w_mdc;
  logic                       w_slot_start;
  logic                       w_sample_strb;
  logic                       w_slot_end;
  logic                       w_last_slot;

  mdc_gen #(.CLK_DIV(CLK_DIV)) u_mdc_gen (
    .clk_50        (clk_50),
    .reset         (reset),
    .i_en          (r_state != ST_IDLE),
    .i_gap         (r_state == ST_GAP),
    .o_mdc         (w_mdc),
    .o_slot_start  (w_slot_start),
    .o_sample_strb (w_sample_strb),
    .o_slot_end    (w_slot_end)
  );

  assign w_accept    = mif.cmd_valid && w_cmd_ready;
  assign w_last_slot = (r_slot == MDIO_SLOT_LAST);

  always_ff @(posedge clk_50) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = ST_XFER;
      ST_XFER: if (w_slot_end && w_last_slot) w_state_nxt = ST_GAP;
      ST_GAP:  if (w_slot_end) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Reads release the line from the first turnaround slot onward.
  always_comb begin
    w_cmd_ready = (r_state == ST_IDLE) && mif.phy_ready;
    w_mdio_oe   = (r_state == ST_XFER) && (r_write || (r_slot <= MDIO_RD_OE_LAST));
    w_mdio_o    = w_mdio_oe ? r_sreg[MDIO_FRAME_LEN-1] : 1'b1;
  end

  always_ff @(posedge clk_50) begin
    if (reset) begin
      r_sreg      <= '1;
      r_slot      <= '0;
      r_write     <= 1'b0;
      r_ta        <= 1'b1;
      r_rd        <= '1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      if (w_accept) begin
        r_sreg  <= mdio_frame(mif.cmd_write, mif.cmd_phy_addr,
                              mif.cmd_reg_addr, mif.cmd_wdata);
        r_slot  <= '0;
        r_write <= mif.cmd_write;
      end else if (r_state == ST_XFER) begin
        if (w_slot_start && (r_slot == '0)) begin
          r_ta <= 1'b1;
          r_rd <= '1;
        end
        if (w_sample_strb && !r_write && (r_slot >= MDIO_SLOT_TA)) begin
          if (r_slot == MDIO_SLOT_TA) r_ta <= mif.mdio_i;
          else                        r_rd <= {r_rd[14:0], mif.mdio_i};
        end
        if (w_slot_end) begin
          r_sreg <= {r_sreg[MDIO_FRAME_LEN-2:0], 1'b1};
          if (w_last_slot) begin
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= r_write ? 16'h0000 : r_rd;
            r_rsp_err   <= r_write ? 1'b0 : r_ta;
          end else begin
            r_slot <= r_slot + 6'd1;
          end
        end
      end
    end
  end

  assign mif.cmd_ready = w_cmd_ready;
  assign mif.rsp_valid = r_rsp_valid;
  assign mif.rsp_rdata = r_rsp_rdata;
  assign mif.rsp_err   = r_rsp_err;
  assign mif.mdc       = w_mdc;
  assign mif.mdio_o    = w_mdio_o;
  assign mif.mdio_oe   = w_mdio_oe;

endmodule
`default_nettype wire
